// File: rtl/vpe_operand_dispatcher.sv
// Packs accepted operand jobs into PIPE_STAGE lane slots and presents the
// bundle to the VPE lane array as one registered transfer; flush issues a partial bundle.
module vpe_operand_dispatcher #(
  parameter int PIPE_STAGE = 2,
  parameter int TILE_SIZE  = 128,
  parameter int MUL_WIDTH  = 16
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  in_valid_i,
  output logic                                  in_ready_o,
  input  logic [TILE_SIZE*MUL_WIDTH-1:0]        in_vec1_i,
  input  logic [TILE_SIZE*MUL_WIDTH-1:0]        in_vec2_i,
  input  logic [MUL_WIDTH-1:0]                  in_scal_i,
  input  logic                                  in_mode_i,
  input  logic                                  flush_i,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic [PIPE_STAGE*TILE_SIZE*MUL_WIDTH-1:0] operand1_o,
  output logic [PIPE_STAGE*TILE_SIZE*MUL_WIDTH-1:0] operand2_o,
  output logic [PIPE_STAGE*MUL_WIDTH-1:0]       operand3_o,
  output logic [PIPE_STAGE-1:0]                 mode_o,
  output logic [PIPE_STAGE-1:0]                 lane_valid_o,
  output logic [$clog2(PIPE_STAGE+1)-1:0]       fill_cnt_o
);

  localparam int VW = TILE_SIZE * MUL_WIDTH;
  localparam int CW = $clog2(PIPE_STAGE + 1);

  typedef enum logic {FILL = 1'b0, ISSUE = 1'b1} state_t;

  state_t                           state, state_nxt;
  logic   [CW-1:0]                  fill_cnt;
  logic                             accept, last_slot, take, vld_p0;
  logic   [PIPE_STAGE-1:0][VW-1:0]        vec1_p0, vec2_p0;
  logic   [PIPE_STAGE-1:0][MUL_WIDTH-1:0] scal_p0;
  logic   [PIPE_STAGE-1:0]                mode_p0, lane_valid_p0;

  assign accept    = in_valid_i & in_ready_o;
  assign last_slot = (fill_cnt == CW'(PIPE_STAGE - 1));
  assign take      = vld_p0 & out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= FILL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL: begin
        if (accept && last_slot)                     state_nxt = ISSUE;
        else if (flush_i && (fill_cnt != '0 || accept)) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (out_ready_i) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_comb begin
    in_ready_o = 1'b0;
    vld_p0     = 1'b0;
    unique case (state)
      FILL:    in_ready_o = 1'b1;
      ISSUE:   vld_p0     = 1'b1;
      default: in_ready_o = 1'b0;
    endcase
  end

  // Stage p0: bundle slots; cleared on reset and on handoff so unfilled lanes read zero
  always_ff @(posedge clk_i) begin
    if (rst_i || take) begin
      vec1_p0       <= '0;
      vec2_p0       <= '0;
      scal_p0       <= '0;
      mode_p0       <= '0;
      lane_valid_p0 <= '0;
      fill_cnt      <= '0;
    end else if (accept) begin
      for (int j = 0; j < PIPE_STAGE; j++) begin
        if (fill_cnt == CW'(j)) begin
          vec1_p0[j]       <= in_vec1_i;
          vec2_p0[j]       <= in_vec2_i;
          scal_p0[j]       <= in_scal_i;
          mode_p0[j]       <= in_mode_i;
          lane_valid_p0[j] <= 1'b1;
        end
      end
      fill_cnt <= fill_cnt + CW'(1);
    end
  end

  assign out_valid_o  = vld_p0;
  assign operand1_o   = vec1_p0;
  assign operand2_o   = vec2_p0;
  assign operand3_o   = scal_p0;
  assign mode_o       = mode_p0;
  assign lane_valid_o = lane_valid_p0;
  assign fill_cnt_o   = fill_cnt;

endmodule

// File: tb/tb_vpe_operand_dispatcher.sv
// Directed table-driven bench for vpe_operand_dispatcher plus reset-in-ISSUE
// and a random valid/ready stream checked against an in-order job queue.
module tb_vpe_operand_dispatcher;
  localparam int PS = 2, TS = 128, MW = 16, VW = TS * MW, CW = $clog2(PS + 1);
  localparam int WW = PS * VW;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_mode, flush, out_valid, out_ready;
  logic [VW-1:0]    in_vec1, in_vec2;
  logic [MW-1:0]    in_scal;
  logic [PS*VW-1:0] operand1, operand2;
  logic [PS*MW-1:0] operand3;
  logic [PS-1:0]    mode, lane_valid;
  logic [CW-1:0]    fill_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vpe_operand_dispatcher #(.PIPE_STAGE(PS), .TILE_SIZE(TS), .MUL_WIDTH(MW)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_vec1_i(in_vec1), .in_vec2_i(in_vec2), .in_scal_i(in_scal), .in_mode_i(in_mode),
    .flush_i(flush), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .operand1_o(operand1), .operand2_o(operand2), .operand3_o(operand3),
    .mode_o(mode), .lane_valid_o(lane_valid), .fill_cnt_o(fill_cnt)
  );

  typedef struct {
    logic        v, fl, rdy;
    logic [15:0] scal;
    logic        md;
    logic        e_ov, e_ir;
    logic [1:0]  e_lv;
    logic [1:0]  e_cnt;
    logic [31:0] e_op3;
    logic [1:0]  e_mode;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int k = 0; k < WW / MW; k++) begin
        if (act[k*MW +: MW] !== exp[k*MW +: MW]) begin
          $display("FAIL %s: element %0d got %h expected %h", name, k, act[k*MW +: MW], exp[k*MW +: MW]);
          break;
        end
      end
    end
  endtask

  // Each job carries its scalar in vec1 element 0 and its complement in vec2 last element
  task automatic drive_job(input logic [MW-1:0] s, input logic m);
    in_scal = s;
    in_mode = m;
    in_vec1 = '0;
    in_vec1[MW-1:0] = s;
    in_vec2 = '0;
    in_vec2[VW-1 -: MW] = ~s;
  endtask

  function automatic logic [WW-1:0] exp_op1(input logic [PS*MW-1:0] s);
    logic [WW-1:0] r;
    r = '0;
    for (int j = 0; j < PS; j++) r[j*VW +: MW] = s[j*MW +: MW];
    return r;
  endfunction

  function automatic logic [WW-1:0] exp_op2(input logic [PS*MW-1:0] s, input logic [PS-1:0] lv);
    logic [WW-1:0] r;
    r = '0;
    for (int j = 0; j < PS; j++)
      if (lv[j]) r[j*VW + VW - MW +: MW] = ~s[j*MW +: MW];
    return r;
  endfunction

  task automatic check_all(input string tag, input logic e_ov, input logic e_ir,
                           input logic [1:0] e_lv, input logic [1:0] e_cnt,
                           input logic [31:0] e_op3, input logic [1:0] e_mode);
    chk({tag, ".out_valid"},  WW'(out_valid),  WW'(e_ov));
    chk({tag, ".in_ready"},   WW'(in_ready),   WW'(e_ir));
    chk({tag, ".lane_valid"}, WW'(lane_valid), WW'(e_lv));
    chk({tag, ".fill_cnt"},   WW'(fill_cnt),   WW'(e_cnt));
    chk({tag, ".operand3"},   WW'(operand3),   WW'(e_op3));
    chk({tag, ".mode"},       WW'(mode),       WW'(e_mode));
    chk({tag, ".operand1"},   operand1,        exp_op1(e_op3));
    chk({tag, ".operand2"},   operand2,        exp_op2(e_op3, e_lv));
  endtask

  initial begin
    logic [MW-1:0] q[$];
    logic [MW-1:0] e;
    int bundles;
    int nxt;

    //        v   fl  rdy  scal      md  ov  ir  lv     cnt    op3                   mode
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'h3C00, 1'b1, 1'b0, 1'b1, 2'b01, 2'd1, 32'h0000_3C00, 2'b01};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 16'h4000, 1'b0, 1'b1, 1'b0, 2'b11, 2'd2, 32'h4000_3C00, 2'b01};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 16'hAAAA, 1'b1, 1'b1, 1'b0, 2'b11, 2'd2, 32'h4000_3C00, 2'b01};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 16'hAAAA, 1'b1, 1'b1, 1'b0, 2'b11, 2'd2, 32'h4000_3C00, 2'b01};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 16'hAAAA, 1'b1, 1'b1, 1'b0, 2'b11, 2'd2, 32'h4000_3C00, 2'b01};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 16'hAAAA, 1'b1, 1'b1, 1'b0, 2'b11, 2'd2, 32'h4000_3C00, 2'b01};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 16'hAAAA, 1'b1, 1'b1, 1'b0, 2'b11, 2'd2, 32'h4000_3C00, 2'b01};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 16'hAAAA, 1'b1, 1'b0, 1'b1, 2'b00, 2'd0, 32'h0000_0000, 2'b00};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 2'b00, 2'd0, 32'h0000_0000, 2'b00};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b1, 2'b01, 2'd1, 32'h0000_1234, 2'b00};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 2'b01, 2'd1, 32'h0000_1234, 2'b00};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 2'b00, 2'd0, 32'h0000_0000, 2'b00};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 16'h5678, 1'b1, 1'b1, 1'b0, 2'b01, 2'd1, 32'h0000_5678, 2'b01};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 2'b01, 2'd1, 32'h0000_5678, 2'b01};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 2'b00, 2'd0, 32'h0000_0000, 2'b00};

    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive_job('0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("reset", 1'b0, 1'b1, 2'b00, 2'd0, 32'h0, 2'b00);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      in_valid = tbl[i].v; flush = tbl[i].fl; out_ready = tbl[i].rdy;
      drive_job(tbl[i].scal, tbl[i].md);
      @(posedge clk);
      @(negedge clk);
      check_all($sformatf("vec%0d", i), tbl[i].e_ov, tbl[i].e_ir, tbl[i].e_lv,
                tbl[i].e_cnt, tbl[i].e_op3, tbl[i].e_mode);
    end

    // Fill a bundle, then reset while it is being offered
    in_valid = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive_job(16'h1111, 1'b1);
    @(posedge clk); @(negedge clk);
    drive_job(16'h2222, 1'b1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check_all("pre_rst", 1'b1, 1'b0, 2'b11, 2'd2, 32'h2222_1111, 2'b11);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check_all("mid_issue_rst", 1'b0, 1'b1, 2'b00, 2'd0, 32'h0, 2'b00);
    rst = 1'b0;

    bundles = 0;
    nxt = 1;
    for (int c = 0; c < 400; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      flush     = 1'b0;
      drive_job(MW'(nxt), nxt[0]);
      if (out_valid && out_ready) begin
        bundles++;
        for (int j = 0; j < PS; j++) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL stream.underflow: bundle %0d lane %0d has no queued job", bundles, j);
          end else begin
            e = q.pop_front();
            chk($sformatf("stream.scal_l%0d", j), WW'(operand3[j*MW +: MW]), WW'(e));
            chk($sformatf("stream.mode_l%0d", j), WW'(mode[j]), WW'(e[0]));
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(MW'(nxt));
        nxt++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("stream.bundles_seen", WW'(bundles > 10), WW'(1'b1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
